pe_controller: RTL and testbench



---
 rtl/pe_pkg.sv | 45 ++++
 rtl/pe_imm_ext.sv | 40 ++++
 rtl/pe_controller.sv | 225 ++++++++++++++++++++++
 tb/tb_pe_controller.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared constants for the PE sequencing controller: opcodes, ALU codes,
// operand/write-back select encodings and the controller state enum.
package pe_pkg;

    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_SLL  = 5'd2;
    localparam logic [4:0] ALU_SLT  = 5'd3;
    localparam logic [4:0] ALU_SLTU = 5'd4;
    localparam logic [4:0] ALU_XOR  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_OR   = 5'd8;
    localparam logic [4:0] ALU_AND  = 5'd9;

    localparam logic [1:0] ASEL_REG  = 2'd0;
    localparam logic [1:0] ASEL_PC   = 2'd1;
    localparam logic [1:0] ASEL_ZERO = 2'd2;
    localparam logic [1:0] BSEL_REG  = 2'd0;
    localparam logic [1:0] BSEL_IMM  = 2'd1;
    localparam logic [1:0] OSEL_ALU  = 2'd0;
    localparam logic [1:0] OSEL_MEM  = 2'd1;
    localparam logic [1:0] OSEL_IMM  = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    function automatic logic isSupported(input logic [6:0] opc);
        return (opc == OPC_OPIMM) || (opc == OPC_OP) || (opc == OPC_LOAD) ||
               (opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_BRANCH);
    endfunction

endpackage

// File: rtl/pe_imm_ext.sv
// Combinational immediate extension (I/U/shift/branch forms) and
// load-data extension selected by the load width in funct3.
module pe_imm_ext
    import pe_pkg::*;
(
    input  logic [6:0]  i_op,
    input  logic [2:0]  i_funct3,
    input  logic [11:0] i_imm12,
    input  logic [19:0] i_immhi,
    input  logic [31:0] i_memData,
    output logic [31:0] o_immValue,
    output logic [31:0] o_immSext,
    output logic [31:0] o_branchOff,
    output logic [31:0] o_loadData
);

    assign o_immSext   = {{20{i_imm12[11]}}, i_imm12};
    assign o_branchOff = {{19{i_imm12[11]}}, i_imm12, 1'b0};

    // Shift-immediates carry only a 5-bit shift amount; upper bits hold funct7.
    always_comb begin
        o_immValue = o_immSext;
        if ((i_op == OPC_LUI) || (i_op == OPC_AUIPC)) begin
            o_immValue = {i_immhi, 12'b0};
        end else if ((i_op == OPC_OPIMM) && (i_funct3[1:0] == 2'b01)) begin
            o_immValue = {27'b0, i_imm12[4:0]};
        end
    end

    always_comb begin
        case (i_funct3)
            3'b000:  o_loadData = {{24{i_memData[7]}}, i_memData[7:0]};
            3'b001:  o_loadData = {{16{i_memData[15]}}, i_memData[15:0]};
            3'b100:  o_loadData = {24'b0, i_memData[7:0]};
            3'b101:  o_loadData = {16'b0, i_memData[15:0]};
            default: o_loadData = i_memData;
        endcase
    end

endmodule

// File: rtl/pe_controller.sv
// Per-PE instruction sequencer: latches decoded fields, then steps through
// operand read, ALU execute, optional load and a single write-back cycle.
module pe_controller
    import pe_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [1:0]  funct2,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  rd,
    input  logic [11:0] imm12,
    input  logic [19:0] immhi,
    input  logic [31:0] PCin,
    input  logic [31:0] result_1,
    input  logic [31:0] result_2,
    input  logic        dataReady,
    input  logic        ALUcomplete,
    input  logic        ALU0,
    input  logic        mem_ack,
    input  logic [31:0] mem_Message,
    output logic [31:0] PCout,
    output logic [4:0]  ALUsel,
    output logic [1:0]  Asel,
    output logic [1:0]  Bsel,
    output logic [1:0]  Osel,
    output logic [4:0]  rs1Out,
    output logic [4:0]  rs2Out,
    output logic [4:0]  rdOut,
    output logic        rdWrite,
    output logic [31:0] Aval,
    output logic [31:0] Bval,
    output logic        Aenable,
    output logic        Benable,
    output logic [31:0] immvalue,
    output logic        mem_read,
    output logic [31:0] mem_address,
    output logic [31:0] messReg
);

    state_t      r_state;
    state_t      w_nextState;
    logic [6:0]  r_op;
    logic [2:0]  r_funct3;
    logic        r_funct7b5;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [4:0]  r_rd;
    logic [11:0] r_imm12;
    logic [19:0] r_immhi;
    logic [31:0] r_pc;
    logic [31:0] r_aval;
    logic [31:0] r_bval;
    logic [31:0] r_messReg;
    logic [31:0] r_pcOut;
    logic        r_aluZero;
    logic [4:0]  w_aluSel;
    logic [1:0]  w_asel;
    logic [1:0]  w_bsel;
    logic [1:0]  w_osel;
    logic [31:0] w_immValue;
    logic [31:0] w_immSext;
    logic [31:0] w_branchOff;
    logic [31:0] w_loadData;
    logic [31:0] w_aSrc;
    logic [31:0] w_bSrc;
    logic        w_taken;
    logic        w_unused;

    assign w_unused = ^{funct2, funct7[6], funct7[4:0]};

    pe_imm_ext u_immExt (
        .i_op        (r_op),
        .i_funct3    (r_funct3),
        .i_imm12     (r_imm12),
        .i_immhi     (r_immhi),
        .i_memData   (mem_Message),
        .o_immValue  (w_immValue),
        .o_immSext   (w_immSext),
        .o_branchOff (w_branchOff),
        .o_loadData  (w_loadData)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: if (isSupported(op)) w_nextState = (op == OPC_LUI) ? S_WB : S_READ;
            S_READ: if (dataReady) w_nextState = S_EXEC;
            S_EXEC: if (ALUcomplete) w_nextState = (r_op == OPC_LOAD) ? S_MEM : S_WB;
            S_MEM:  if (mem_ack) w_nextState = S_WB;
            S_WB:   w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    // Decode works only from latched fields so mid-instruction decoder changes are invisible.
    always_comb begin
        w_aluSel = ALU_ADD;
        w_asel   = ASEL_REG;
        w_bsel   = BSEL_REG;
        w_osel   = OSEL_ALU;
        case (r_op)
            OPC_OPIMM, OPC_OP: begin
                w_bsel = (r_op == OPC_OPIMM) ? BSEL_IMM : BSEL_REG;
                case (r_funct3)
                    3'b000:  w_aluSel = ((r_op == OPC_OP) && r_funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  w_aluSel = ALU_SLL;
                    3'b010:  w_aluSel = ALU_SLT;
                    3'b011:  w_aluSel = ALU_SLTU;
                    3'b100:  w_aluSel = ALU_XOR;
                    3'b101:  w_aluSel = r_funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  w_aluSel = ALU_OR;
                    default: w_aluSel = ALU_AND;
                endcase
            end
            OPC_LOAD: begin
                w_bsel = BSEL_IMM;
                w_osel = OSEL_MEM;
            end
            OPC_LUI: begin
                w_asel = ASEL_ZERO;
                w_bsel = BSEL_IMM;
                w_osel = OSEL_IMM;
            end
            OPC_AUIPC: begin
                w_asel = ASEL_PC;
                w_bsel = BSEL_IMM;
            end
            OPC_BRANCH: begin
                w_aluSel = !r_funct3[2] ? ALU_SUB : (r_funct3[1] ? ALU_SLTU : ALU_SLT);
            end
            default: ;
        endcase
    end

    always_comb begin
        w_aSrc = '0;
        case (w_asel)
            ASEL_REG:  w_aSrc = result_1;
            ASEL_PC:   w_aSrc = r_pc;
            ASEL_ZERO: w_aSrc = '0;
            default:   ;
        endcase
    end

    assign w_bSrc = (w_bsel == BSEL_IMM) ? w_immValue : result_2;

    // Equal/greater-or-equal forms branch on a zero ALU result, the others on non-zero.
    assign w_taken = (r_op == OPC_BRANCH) && (r_aluZero ^ (r_funct3[2] ^ r_funct3[0]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op       <= '0;
            r_funct3   <= '0;
            r_funct7b5 <= 1'b0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_imm12    <= '0;
            r_immhi    <= '0;
            r_pc       <= '0;
            r_aval     <= '0;
            r_bval     <= '0;
            r_messReg  <= '0;
            r_pcOut    <= '0;
            r_aluZero  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (isSupported(op)) begin
                        r_op       <= op;
                        r_funct3   <= funct3;
                        r_funct7b5 <= funct7[5];
                        r_rs1      <= rs1;
                        r_rs2      <= rs2;
                        r_rd       <= rd;
                        r_imm12    <= imm12;
                        r_immhi    <= immhi;
                        r_pc       <= PCin;
                    end
                end
                S_READ: begin
                    if (dataReady) begin
                        r_aval <= w_aSrc;
                        r_bval <= w_bSrc;
                    end
                end
                S_EXEC: if (ALUcomplete) r_aluZero <= ALU0;
                S_MEM:  if (mem_ack) r_messReg <= w_loadData;
                S_WB:   r_pcOut <= w_taken ? (r_pc + w_branchOff) : (r_pc + 32'd4);
                default: ;
            endcase
        end
    end

    assign PCout       = r_pcOut;
    assign ALUsel      = w_aluSel;
    assign Asel        = w_asel;
    assign Bsel        = w_bsel;
    assign Osel        = w_osel;
    assign rs1Out      = r_rs1;
    assign rs2Out      = r_rs2;
    assign rdOut       = r_rd;
    assign rdWrite     = (r_state == S_WB) && (r_rd != 5'd0) && (r_op != OPC_BRANCH);
    assign Aval        = r_aval;
    assign Bval        = r_bval;
    assign Aenable     = (r_state == S_EXEC);
    assign Benable     = (r_state == S_EXEC);
    assign immvalue    = w_immValue;
    assign mem_read    = (r_state == S_MEM);
    assign mem_address = (r_op == OPC_LOAD) ? (r_aval + w_immSext) : '0;
    assign messReg     = r_messReg;

endmodule

// File: tb/tb_pe_controller.sv
// Directed bench for pe_controller: a table of single-instruction vectors
// plus hand-written load, LUI, abort and ignored-opcode sequences.
module tb_pe_controller;

    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] OPR    = 7'b0110011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] BRANCH = 7'b1100011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  op = '0;
    logic [2:0]  funct3 = '0;
    logic [6:0]  funct7 = '0;
    logic [1:0]  funct2 = '0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic [4:0]  rd = '0;
    logic [11:0] imm12 = '0;
    logic [19:0] immhi = '0;
    logic [31:0] PCin = '0;
    logic [31:0] result_1 = '0;
    logic [31:0] result_2 = '0;
    logic        dataReady = 1'b0;
    logic        ALUcomplete = 1'b0;
    logic        ALU0 = 1'b0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_Message = '0;
    logic [31:0] PCout;
    logic [4:0]  ALUsel;
    logic [1:0]  Asel;
    logic [1:0]  Bsel;
    logic [1:0]  Osel;
    logic [4:0]  rs1Out;
    logic [4:0]  rs2Out;
    logic [4:0]  rdOut;
    logic        rdWrite;
    logic [31:0] Aval;
    logic [31:0] Bval;
    logic        Aenable;
    logic        Benable;
    logic [31:0] immvalue;
    logic        mem_read;
    logic [31:0] mem_address;
    logic [31:0] messReg;

    int nChecks = 0;
    int nFails = 0;

    typedef struct {
        string       name;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rs1, rs2, rd;
        logic [11:0] imm12;
        logic [19:0] immhi;
        logic [31:0] pc, r1, r2;
        logic        alu0;
        logic [31:0] eAlu, eAsel, eBsel, eOsel, eImm, eAval, eBval, eWr, ePc;
    } vec_t;

    vec_t vecs[14];

    pe_controller dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op          (op),
        .funct3      (funct3),
        .funct7      (funct7),
        .funct2      (funct2),
        .rs1         (rs1),
        .rs2         (rs2),
        .rd          (rd),
        .imm12       (imm12),
        .immhi       (immhi),
        .PCin        (PCin),
        .result_1    (result_1),
        .result_2    (result_2),
        .dataReady   (dataReady),
        .ALUcomplete (ALUcomplete),
        .ALU0        (ALU0),
        .mem_ack     (mem_ack),
        .mem_Message (mem_Message),
        .PCout       (PCout),
        .ALUsel      (ALUsel),
        .Asel        (Asel),
        .Bsel        (Bsel),
        .Osel        (Osel),
        .rs1Out      (rs1Out),
        .rs2Out      (rs2Out),
        .rdOut       (rdOut),
        .rdWrite     (rdWrite),
        .Aval        (Aval),
        .Bval        (Bval),
        .Aenable     (Aenable),
        .Benable     (Benable),
        .immvalue    (immvalue),
        .mem_read    (mem_read),
        .mem_address (mem_address),
        .messReg     (messReg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic scrambleDecoder();
        op     = 7'd0;
        funct3 = 3'd6;
        funct7 = 7'h7F;
        rs1    = 5'd31;
        rs2    = 5'd30;
        rd     = 5'd29;
        imm12  = 12'hABC;
        immhi  = 20'hFFFFF;
        PCin   = 32'hDEADBEEF;
    endtask

    task automatic applyStimulus(input vec_t v);
        op     = v.op;
        funct3 = v.f3;
        funct7 = v.f7;
        rs1    = v.rs1;
        rs2    = v.rs2;
        rd     = v.rd;
        imm12  = v.imm12;
        immhi  = v.immhi;
        PCin   = v.pc;
        tick();
        scrambleDecoder();
        checkOutput({v.name, " rs1Out"}, 32'(rs1Out), 32'(v.rs1));
        checkOutput({v.name, " rs2Out"}, 32'(rs2Out), 32'(v.rs2));
        result_1  = v.r1;
        result_2  = v.r2;
        dataReady = 1'b1;
        tick();
        dataReady = 1'b0;
        result_1  = 32'h0BAD0BAD;
        result_2  = 32'h0BAD0BAD;
        checkOutput({v.name, " enables"}, 32'({Aenable, Benable}), 32'd3);
        checkOutput({v.name, " ALUsel"}, 32'(ALUsel), v.eAlu);
        checkOutput({v.name, " Asel"}, 32'(Asel), v.eAsel);
        checkOutput({v.name, " Bsel"}, 32'(Bsel), v.eBsel);
        checkOutput({v.name, " immvalue"}, immvalue, v.eImm);
        checkOutput({v.name, " Aval"}, Aval, v.eAval);
        checkOutput({v.name, " Bval"}, Bval, v.eBval);
        ALUcomplete = 1'b1;
        ALU0        = v.alu0;
        tick();
        ALUcomplete = 1'b0;
        ALU0        = 1'b0;
        checkOutput({v.name, " Osel"}, 32'(Osel), v.eOsel);
        checkOutput({v.name, " rdWrite"}, 32'(rdWrite), v.eWr);
        checkOutput({v.name, " rdOut"}, 32'(rdOut), 32'(v.rd));
        tick();
        checkOutput({v.name, " PCout"}, PCout, v.ePc);
        checkOutput({v.name, " rdWrite after WB"}, 32'(rdWrite), 32'd0);
    endtask

    task automatic runLoad(input string name, input logic [2:0] f3, input logic [11:0] imm,
                           input logic [31:0] r1, input int waits, input logic earlyAck,
                           input logic [31:0] msg, input logic [31:0] expAddr,
                           input logic [31:0] expMess);
        op     = LOAD;
        funct3 = f3;
        rs1    = 5'd1;
        rd     = 5'd4;
        imm12  = imm;
        PCin   = 32'h500;
        tick();
        scrambleDecoder();
        result_1  = r1;
        dataReady = 1'b1;
        tick();
        dataReady   = 1'b0;
        mem_ack     = earlyAck;
        mem_Message = 32'h11111111;
        checkOutput({name, " mem_read in EXEC"}, 32'(mem_read), 32'd0);
        ALUcomplete = 1'b1;
        tick();
        ALUcomplete = 1'b0;
        mem_ack     = 1'b0;
        for (int i = 0; i < waits; i++) begin
            checkOutput($sformatf("%s mem_read wait%0d", name, i), 32'(mem_read), 32'd1);
            checkOutput($sformatf("%s mem_address wait%0d", name, i), mem_address, expAddr);
            tick();
        end
        mem_ack     = 1'b1;
        mem_Message = msg;
        checkOutput({name, " mem_read at ack"}, 32'(mem_read), 32'd1);
        checkOutput({name, " mem_address at ack"}, mem_address, expAddr);
        tick();
        mem_ack = 1'b0;
        checkOutput({name, " messReg"}, messReg, expMess);
        checkOutput({name, " Osel"}, 32'(Osel), 32'd1);
        checkOutput({name, " rdWrite"}, 32'(rdWrite), 32'd1);
        checkOutput({name, " mem_read in WB"}, 32'(mem_read), 32'd0);
        tick();
        checkOutput({name, " PCout"}, PCout, 32'h504);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{"ADDI",  OPIMM,  3'd0, 7'h00, 5'd2,  5'd0, 5'd2,  12'h006, 20'h0,     32'h0,    32'd10,        32'd0,      1'b0,
                     32'd0, 32'd0, 32'd1, 32'd0, 32'd6,          32'd10,        32'd6,          32'd1, 32'h4};
        vecs[1]  = '{"SLLI",  OPIMM,  3'd1, 7'h00, 5'd2,  5'd0, 5'd2,  12'h006, 20'h0,     32'h1,    32'd10,        32'd0,      1'b0,
                     32'd2, 32'd0, 32'd1, 32'd0, 32'd6,          32'd10,        32'd6,          32'd1, 32'h5};
        vecs[2]  = '{"SRAI",  OPIMM,  3'd5, 7'h20, 5'd3,  5'd0, 5'd3,  12'h405, 20'h0,     32'h20,   32'h80000000,  32'd0,      1'b0,
                     32'd7, 32'd0, 32'd1, 32'd0, 32'd5,          32'h80000000,  32'd5,          32'd1, 32'h24};
        vecs[3]  = '{"SUB",   OPR,    3'd0, 7'h20, 5'd1,  5'd4, 5'd7,  12'h000, 20'h0,     32'h8,    32'd100,       32'd30,     1'b0,
                     32'd1, 32'd0, 32'd0, 32'd0, 32'd0,          32'd100,       32'd30,         32'd1, 32'hC};
        vecs[4]  = '{"AND-x0",OPR,    3'd7, 7'h00, 5'd5,  5'd6, 5'd0,  12'h000, 20'h0,     32'h40,   32'h0000F0F0,  32'h00000FF0, 1'b0,
                     32'd9, 32'd0, 32'd0, 32'd0, 32'd0,          32'h0000F0F0,  32'h00000FF0,   32'd0, 32'h44};
        vecs[5]  = '{"ADDI-n",OPIMM,  3'd0, 7'h00, 5'd8,  5'd0, 5'd8,  12'hFFF, 20'h0,     32'h10,   32'd5,         32'd0,      1'b0,
                     32'd0, 32'd0, 32'd1, 32'd0, 32'hFFFFFFFF,   32'd5,         32'hFFFFFFFF,   32'd1, 32'h14};
        vecs[6]  = '{"AUIPC", AUIPC,  3'd0, 7'h00, 5'd0,  5'd0, 5'd9,  12'h000, 20'hABCDE, 32'h1000, 32'h77,        32'd0,      1'b0,
                     32'd0, 32'd1, 32'd1, 32'd0, 32'hABCDE000,   32'h1000,      32'hABCDE000,   32'd1, 32'h1004};
        vecs[7]  = '{"BEQ-t", BRANCH, 3'd0, 7'h00, 5'd1,  5'd2, 5'd5,  12'h008, 20'h0,     32'h100,  32'd7,         32'd7,      1'b1,
                     32'd1, 32'd0, 32'd0, 32'd0, 32'd8,          32'd7,         32'd7,          32'd0, 32'h110};
        vecs[8]  = '{"BNE-n", BRANCH, 3'd1, 7'h00, 5'd1,  5'd2, 5'd5,  12'h008, 20'h0,     32'h100,  32'd7,         32'd7,      1'b1,
                     32'd1, 32'd0, 32'd0, 32'd0, 32'd8,          32'd7,         32'd7,          32'd0, 32'h104};
        vecs[9]  = '{"BLT-t", BRANCH, 3'd4, 7'h00, 5'd3,  5'd4, 5'd6,  12'hFFC, 20'h0,     32'h200,  32'hFFFFFFFF,  32'd1,      1'b0,
                     32'd3, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFC,   32'hFFFFFFFF,  32'd1,          32'd0, 32'h1F8};
        vecs[10] = '{"BGEU-n",BRANCH, 3'd7, 7'h00, 5'd3,  5'd4, 5'd6,  12'h010, 20'h0,     32'h300,  32'd1,         32'd2,      1'b0,
                     32'd4, 32'd0, 32'd0, 32'd0, 32'h10,         32'd1,         32'd2,          32'd0, 32'h304};
        vecs[11] = '{"SLTIU", OPIMM,  3'd3, 7'h00, 5'd10, 5'd0, 5'd11, 12'h001, 20'h0,     32'h44,   32'd0,         32'd0,      1'b0,
                     32'd4, 32'd0, 32'd1, 32'd0, 32'd1,          32'd0,         32'd1,          32'd1, 32'h48};
        vecs[12] = '{"XORI",  OPIMM,  3'd4, 7'h20, 5'd12, 5'd0, 5'd13, 12'h0FF, 20'h0,     32'h60,   32'h55,        32'd0,      1'b0,
                     32'd5, 32'd0, 32'd1, 32'd0, 32'hFF,         32'h55,        32'hFF,         32'd1, 32'h64};
        vecs[13] = '{"BGE-t", BRANCH, 3'd5, 7'h00, 5'd3,  5'd4, 5'd6,  12'h020, 20'h0,     32'h400,  32'd3,         32'd3,      1'b1,
                     32'd3, 32'd0, 32'd0, 32'd0, 32'h20,         32'd3,         32'd3,          32'd0, 32'h440};

        // Reset state
        tick();
        tick();
        checkOutput("reset PCout", PCout, 32'd0);
        checkOutput("reset strobes", 32'({rdWrite, Aenable, Benable, mem_read}), 32'd0);
        checkOutput("reset selects", 32'({ALUsel, Asel, Bsel, Osel}), 32'd0);
        checkOutput("reset immvalue", immvalue, 32'd0);
        checkOutput("reset Aval", Aval, 32'd0);
        checkOutput("reset messReg", messReg, 32'd0);
        checkOutput("reset mem_address", mem_address, 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i]);
        end

        runLoad("LB",  3'd0, 12'h801, 32'h1,    2, 1'b0, 32'h00000080, 32'hFFFFF802, 32'hFFFFFF80);
        runLoad("LHU", 3'd5, 12'h004, 32'h1000, 0, 1'b1, 32'hABCD8765, 32'h00001004, 32'h00008765);
        runLoad("LH",  3'd1, 12'h000, 32'h2000, 1, 1'b0, 32'h12348765, 32'h00002000, 32'hFFFF8765);
        runLoad("LW",  3'd2, 12'h008, 32'h3000, 0, 1'b0, 32'hDEADBEEF, 32'h00003008, 32'hDEADBEEF);

        // Unsupported opcodes with every handshake asserted must stay idle
        dataReady   = 1'b1;
        ALUcomplete = 1'b1;
        mem_ack     = 1'b1;
        op          = 7'd0;
        rd          = 5'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("op0 strobes c%0d", i), 32'({rdWrite, Aenable, Benable, mem_read}), 32'd0);
        end
        op = 7'h7F;
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput($sformatf("op7F strobes c%0d", i), 32'({rdWrite, Aenable, Benable, mem_read}), 32'd0);
        end
        op          = 7'd0;
        dataReady   = 1'b0;
        ALUcomplete = 1'b0;
        mem_ack     = 1'b0;
        tick();

        // Reset asserted while in EXEC aborts the instruction
        op     = OPIMM;
        funct3 = 3'd0;
        rs1    = 5'd2;
        rd     = 5'd6;
        imm12  = 12'h001;
        PCin   = 32'h80;
        tick();
        scrambleDecoder();
        result_1  = 32'd3;
        dataReady = 1'b1;
        tick();
        dataReady   = 1'b0;
        ALUcomplete = 1'b1;
        checkOutput("abort in EXEC", 32'(Aenable), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort strobes", 32'({rdWrite, Aenable, Benable, mem_read}), 32'd0);
        checkOutput("abort PCout", PCout, 32'd0);
        checkOutput("abort Aval", Aval, 32'd0);
        checkOutput("abort immvalue", immvalue, 32'd0);
        checkOutput("abort rs1Out/rdOut", 32'({rs1Out, rdOut}), 32'd0);
        tick();
        ALUcomplete = 1'b0;
        rst_n       = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("post-abort rdWrite c%0d", i), 32'(rdWrite), 32'd0);
            checkOutput($sformatf("post-abort PCout c%0d", i), PCout, 32'd0);
        end

        // LUI skips read/execute and writes back on the next cycle
        op    = LUI;
        immhi = 20'h12345;
        rd    = 5'd5;
        PCin  = 32'h50;
        tick();
        scrambleDecoder();
        checkOutput("LUI rdWrite", 32'(rdWrite), 32'd1);
        checkOutput("LUI rdOut", 32'(rdOut), 32'd5);
        checkOutput("LUI immvalue", immvalue, 32'h12345000);
        checkOutput("LUI Osel", 32'(Osel), 32'd2);
        checkOutput("LUI Aenable", 32'(Aenable), 32'd0);
        tick();
        checkOutput("LUI rdWrite after WB", 32'(rdWrite), 32'd0);
        checkOutput("LUI PCout", PCout, 32'h54);

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
        $finish;
    end

endmodule
